// File: rtl/hs_lock_pkg.sv
// Shared types and constants for the header-lock controller.
package hs_lock_pkg;

  localparam int BUF_W = 67;
  localparam int POS_W = 7;

  localparam logic [1:0] HDR_DATA = 2'b01;
  localparam logic [1:0] HDR_CTRL = 2'b10;

  typedef enum logic [1:0] {
    SEEK_RST,
    SEARCH,
    VERIFY,
    LOCKED
  } lock_state_e;

endpackage

// File: rtl/hs_hdr_check.sv
// Combinational check of the 2-bit sync header at bit position off of the frame buffer.
module hs_hdr_check
  import hs_lock_pkg::*;
(
  input  logic [BUF_W-1:0] buffer,
  input  logic [POS_W-1:0] off,
  output logic             hdr_ok
);

  logic [1:0] hdr;

  // Offsets past BUF_W-2 would need bits beyond the buffer, so they never match.
  always_comb begin
    hdr    = 2'(buffer >> off);
    hdr_ok = (off <= POS_W'(BUF_W - 2)) && ((hdr == HDR_DATA) || (hdr == HDR_CTRL));
  end

endmodule

// File: rtl/hs_lock_ctrl.sv
// Header-alignment lock FSM: seeker reset, search, verify, locked with windowed error count.
// Statistics counters are built only when HS_LOCK_STATS_EN is defined.
module hs_lock_ctrl
  import hs_lock_pkg::*;
#(
  parameter int LOCK_CNT     = 32,
  parameter int UNLOCK_ERR   = 4,
  parameter int WINDOW       = 64,
  parameter int SEEK_TIMEOUT = 1024
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             buffer_dv,
  input  logic [BUF_W-1:0] buffer,
  input  logic             seek_synced_i,
  input  logic [POS_W-1:0] seek_offset_i,
  input  logic             relock_i,
  output logic             seek_rst_o,
  output logic             lock_o,
  output logic [POS_W-1:0] lock_offset_o,
  output logic [15:0]      hdr_err_cnt_o,
  output logic [7:0]       lock_loss_cnt_o
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int ERR_W  = $clog2(UNLOCK_ERR + 1);
  localparam int WIN_W  = $clog2(WINDOW + 1);
  localparam int BEAT_W = $clog2(SEEK_TIMEOUT + 1);

  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
  localparam logic [ERR_W-1:0]  ERR_LAST  = ERR_W'(UNLOCK_ERR - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(SEEK_TIMEOUT - 1);

  lock_state_e       state_q, state_d;
  logic              rst_cnt_q, rst_cnt_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [POS_W-1:0]  cand_off_q, cand_off_d;
  logic [POS_W-1:0]  lock_off_q, lock_off_d;
  logic [POS_W-1:0]  chk_off;
  logic              hdr_ok;

  assign chk_off = (state_q == LOCKED) ? lock_off_q : cand_off_q;

  hs_hdr_check u_hdr_check (
    .buffer (buffer),
    .off    (chk_off),
    .hdr_ok (hdr_ok)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    beat_d     = beat_q;
    good_d     = good_q;
    win_d      = win_q;
    err_d      = err_q;
    cand_off_d = cand_off_q;
    lock_off_d = lock_off_q;

    case (state_q)
      SEEK_RST: begin
        beat_d = '0;
        good_d = '0;
        win_d  = '0;
        err_d  = '0;
        if (rst_cnt_q) begin
          state_d   = SEARCH;
          rst_cnt_d = 1'b0;
        end else begin
          rst_cnt_d = 1'b1;
        end
      end
      SEARCH: begin
        if (buffer_dv) begin
          if (seek_synced_i) begin
            cand_off_d = seek_offset_i;
            state_d    = VERIFY;
          end else if (beat_q == BEAT_LAST) begin
            state_d = SEEK_RST;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      VERIFY: begin
        if (buffer_dv) begin
          if (!hdr_ok) begin
            state_d = SEEK_RST;
          end else if (good_q == GOOD_LAST) begin
            state_d    = LOCKED;
            lock_off_d = cand_off_q;
          end else begin
            good_d = good_q + GOOD_W'(1);
          end
        end
      end
      LOCKED: begin
        if (buffer_dv) begin
          // The unlock test sees the closing beat's error before the window clears.
          if (!hdr_ok && (err_q == ERR_LAST)) begin
            state_d = SEEK_RST;
          end else if (win_q == WIN_LAST) begin
            win_d = '0;
            err_d = '0;
          end else begin
            win_d = win_q + WIN_W'(1);
            err_d = err_q + ERR_W'(!hdr_ok);
          end
        end
      end
      default: state_d = SEEK_RST;
    endcase

    if (relock_i) begin
      state_d   = SEEK_RST;
      rst_cnt_d = 1'b0;
    end

    if (state_d == SEEK_RST) begin
      lock_off_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= SEEK_RST;
      rst_cnt_q  <= 1'b0;
      beat_q     <= '0;
      good_q     <= '0;
      win_q      <= '0;
      err_q      <= '0;
      cand_off_q <= '0;
      lock_off_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      beat_q     <= beat_d;
      good_q     <= good_d;
      win_q      <= win_d;
      err_q      <= err_d;
      cand_off_q <= cand_off_d;
      lock_off_q <= lock_off_d;
    end
  end

  assign seek_rst_o    = (state_q == SEEK_RST);
  assign lock_o        = (state_q == LOCKED);
  assign lock_offset_o = lock_off_q;

`ifdef HS_LOCK_STATS_EN
  logic        hdr_err;
  logic        lock_lost;
  logic [15:0] hdr_err_cnt_q;
  logic [7:0]  lock_loss_cnt_q;

  assign hdr_err   = (state_q == LOCKED) && buffer_dv && !hdr_ok;
  assign lock_lost = (state_q == LOCKED) && (state_d == SEEK_RST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hdr_err_cnt_q   <= '0;
      lock_loss_cnt_q <= '0;
    end else begin
      if (hdr_err && !(&hdr_err_cnt_q)) begin
        hdr_err_cnt_q <= hdr_err_cnt_q + 16'd1;
      end
      if (lock_lost && !(&lock_loss_cnt_q)) begin
        lock_loss_cnt_q <= lock_loss_cnt_q + 8'd1;
      end
    end
  end

  assign hdr_err_cnt_o   = hdr_err_cnt_q;
  assign lock_loss_cnt_o = lock_loss_cnt_q;
`else
  assign hdr_err_cnt_o   = '0;
  assign lock_loss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hs_lock_ctrl.sv
// Directed self-checking bench for hs_lock_ctrl: a cycle-by-cycle vector table plus
// hand-written lock, window-error, timeout, relock and async-reset sequences.
module tb_hs_lock_ctrl;
  import hs_lock_pkg::*;

`ifdef HS_LOCK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam int LOCK_CNT     = 32;
  localparam int WINDOW       = 64;
  localparam int SEEK_TIMEOUT = 1024;

  logic             clk_i         = 1'b0;
  logic             rst_ni        = 1'b0;
  logic             buffer_dv     = 1'b0;
  logic [BUF_W-1:0] buffer        = '0;
  logic             seek_synced_i = 1'b0;
  logic [POS_W-1:0] seek_offset_i = '0;
  logic             relock_i      = 1'b0;
  logic             seek_rst_o;
  logic             lock_o;
  logic [POS_W-1:0] lock_offset_o;
  logic [15:0]      hdr_err_cnt_o;
  logic [7:0]       lock_loss_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       dv;
    logic       sync;
    int         soff;
    logic [1:0] hdr;
    int         hpos;
    logic       relock;
    logic       exp_srst;
    logic       exp_lock;
  } vec_t;

  vec_t vecs[16];

  always #5 clk_i = ~clk_i;

  hs_lock_ctrl #(
    .LOCK_CNT     (LOCK_CNT),
    .UNLOCK_ERR   (4),
    .WINDOW       (WINDOW),
    .SEEK_TIMEOUT (SEEK_TIMEOUT)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .buffer_dv       (buffer_dv),
    .buffer          (buffer),
    .seek_synced_i   (seek_synced_i),
    .seek_offset_i   (seek_offset_i),
    .relock_i        (relock_i),
    .seek_rst_o      (seek_rst_o),
    .lock_o          (lock_o),
    .lock_offset_o   (lock_offset_o),
    .hdr_err_cnt_o   (hdr_err_cnt_o),
    .lock_loss_cnt_o (lock_loss_cnt_o)
  );

  function automatic int exp_stat(input int v);
    return STATS ? v : 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Header placed at pos; positions past BUF_W-2 put hdr[0] in the top bit only.
  task automatic drive(input logic dv, input logic [1:0] hdr, input int pos,
                       input logic sync, input int soff, input logic relock);
    logic [BUF_W-1:0] b;
    b = '0;
    if (pos <= BUF_W - 2) b[pos +: 2] = hdr;
    else                  b[BUF_W-1]  = hdr[0];
    buffer        = b;
    buffer_dv     = dv;
    seek_synced_i = sync;
    seek_offset_i = POS_W'(soff);
    relock_i      = relock;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 0, 1'b0, 0, 1'b0);
    tick();
  endtask

  // From SEARCH: sync at pos, then LOCK_CNT valid headers; lock must appear only after the last.
  task automatic lock_at(input int pos, input string tag);
    drive(1'b1, 2'b00, 0, 1'b1, pos, 1'b0);
    tick();
    check({tag, "_sync_srst"}, seek_rst_o, 1'b0);
    for (int i = 1; i <= LOCK_CNT; i++) begin
      drive(1'b1, (i % 2 == 1) ? HDR_DATA : HDR_CTRL, pos, 1'b0, 0, 1'b0);
      tick();
      if (i == LOCK_CNT - 1) check({tag, "_lock_early"}, lock_o, 1'b0);
    end
    check({tag, "_lock"}, lock_o, 1'b1);
    check({tag, "_offset"}, lock_offset_o, pos);
    drive(1'b0, 2'b00, 0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 12, 2'b01, 12, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 12, 2'b01, 12, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 12, 2'b01, 12, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 66, 2'b00, 0,  1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 0,  2'b01, 66, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 0,  2'b00, 0,  1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 0,  2'b00, 0,  1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 65, 2'b00, 0,  1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 0,  2'b10, 65, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 0,  2'b00, 65, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 0,  2'b01, 65, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 0,  2'b01, 65, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 0,  2'b00, 0,  1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 0,  2'b00, 0,  1'b1, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 0,  2'b00, 0,  1'b0, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 0,  2'b00, 0,  1'b0, 1'b0, 1'b0};

    // Reset state, held across a couple of edges.
    #3;
    check("rst_srst", seek_rst_o, 1'b1);
    check("rst_lock", lock_o, 1'b0);
    check("rst_off", lock_offset_o, 0);
    check("rst_hdr_err", hdr_err_cnt_o, 0);
    check("rst_loss", lock_loss_cnt_o, 0);
    tick();
    tick();
    check("rst_hold_srst", seek_rst_o, 1'b1);
    rst_ni = 1'b1;
    #1;
    check("rel_srst", seek_rst_o, 1'b1);

    // Table: reset pulse, offset 66/65 boundary, dv gating, relock restart of the pulse.
    for (int v = 0; v < 16; v++) begin
      drive(vecs[v].dv, vecs[v].hdr, vecs[v].hpos, vecs[v].sync, vecs[v].soff, vecs[v].relock);
      tick();
      check($sformatf("vec%0d_srst", v), seek_rst_o, vecs[v].exp_srst);
      check($sformatf("vec%0d_lock", v), lock_o, vecs[v].exp_lock);
    end
    drive(1'b0, 2'b00, 0, 1'b0, 0, 1'b0);

    // Lock at offset 12.
    lock_at(12, "lock12");

    // Two windows of 3 errors each, seeker offset wiggling, idle beats with bad headers.
    for (int k = 1; k <= 2 * WINDOW; k++) begin
      drive(1'b1, (k == 5 || k == 20 || k == 40 || k == 70 || k == 100 || k == 128) ? 2'b00 : HDR_DATA,
            12, 1'b1, 40, 1'b0);
      tick();
      if (k == WINDOW) begin
        drive(1'b0, 2'b00, 12, 1'b1, 40, 1'b0);
        tick();
        tick();
        check("win1_lock", lock_o, 1'b1);
      end
    end
    check("win2_lock", lock_o, 1'b1);
    check("win2_srst", seek_rst_o, 1'b0);
    check("win2_offset", lock_offset_o, 12);
    check("win2_hdr_err", hdr_err_cnt_o, exp_stat(6));

    // Four errors in one window, the fourth on the closing beat.
    for (int k = 1; k <= WINDOW; k++) begin
      drive(1'b1, (k == 1 || k == 30 || k == 50 || k == WINDOW) ? 2'b00 : HDR_CTRL, 12, 1'b0, 0, 1'b0);
      tick();
      if (k == WINDOW - 1) check("unlock_before", lock_o, 1'b1);
    end
    check("unlock_lock", lock_o, 1'b0);
    check("unlock_srst", seek_rst_o, 1'b1);
    check("unlock_loss", lock_loss_cnt_o, exp_stat(1));
    check("unlock_hdr_err", hdr_err_cnt_o, exp_stat(10));
    idle();
    check("unlock_srst2", seek_rst_o, 1'b1);
    idle();
    check("unlock_srst_end", seek_rst_o, 1'b0);

    // Verify failure on beat 10.
    drive(1'b1, 2'b00, 0, 1'b1, 12, 1'b0);
    tick();
    for (int k = 1; k <= 10; k++) begin
      drive(1'b1, (k == 10) ? 2'b00 : HDR_DATA, 12, 1'b0, 0, 1'b0);
      tick();
      if (k == 9) check("vfail_srst_early", seek_rst_o, 1'b0);
    end
    check("vfail_srst", seek_rst_o, 1'b1);
    check("vfail_lock", lock_o, 1'b0);
    idle();
    check("vfail_srst2", seek_rst_o, 1'b1);
    idle();
    check("vfail_srst_end", seek_rst_o, 1'b0);
    check("vfail_lock_end", lock_o, 1'b0);

    // Search timeout; idle cycles (with sync but no dv) must neither count nor capture.
    for (int k = 1; k <= SEEK_TIMEOUT; k++) begin
      drive(1'b1, 2'b00, 0, 1'b0, 0, 1'b0);
      tick();
      if (k % 256 == 0 && k < SEEK_TIMEOUT) begin
        drive(1'b0, 2'b00, 0, 1'b1, 5, 1'b0);
        tick();
      end
      if (k == SEEK_TIMEOUT - 1) check("tmo_early", seek_rst_o, 1'b0);
    end
    check("tmo_srst", seek_rst_o, 1'b1);
    idle();
    check("tmo_srst2", seek_rst_o, 1'b1);
    idle();
    check("tmo_search", seek_rst_o, 1'b0);

    // Relock while locked.
    lock_at(20, "lock20");
    drive(1'b1, HDR_DATA, 20, 1'b0, 0, 1'b1);
    tick();
    check("relock_lock", lock_o, 1'b0);
    check("relock_srst", seek_rst_o, 1'b1);
    check("relock_loss", lock_loss_cnt_o, exp_stat(2));
    idle();
    idle();
    check("relock_search", seek_rst_o, 1'b0);

    // Async reset mid-VERIFY.
    drive(1'b1, 2'b00, 0, 1'b1, 20, 1'b0);
    tick();
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, HDR_DATA, 20, 1'b0, 0, 1'b0);
      tick();
    end
    #1 rst_ni = 1'b0;
    #1;
    check("arst_srst", seek_rst_o, 1'b1);
    check("arst_lock", lock_o, 1'b0);
    check("arst_off", lock_offset_o, 0);
    check("arst_hdr_err", hdr_err_cnt_o, 0);
    check("arst_loss", lock_loss_cnt_o, 0);
    drive(1'b0, 2'b00, 0, 1'b0, 0, 1'b0);
    tick();
    rst_ni = 1'b1;
    tick();
    check("arst_rel_srst", seek_rst_o, 1'b1);
    tick();
    check("arst_rel_search", seek_rst_o, 1'b0);

    // Async reset while locked clears the offset too.
    lock_at(33, "lock33");
    #1 rst_ni = 1'b0;
    #1;
    check("arst_locked_lock", lock_o, 1'b0);
    check("arst_locked_off", lock_offset_o, 0);
    check("arst_locked_srst", seek_rst_o, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hs_lock_ctrl.md
HS_LOCK_CTRL -- requirements
Module: hs_lock_ctrl

Interface
REQ-001 The block SHALL have parameter LOCK_CNT, default 32: consecutive valid headers required before lock is declared.
REQ-002 The block SHALL have parameter UNLOCK_ERR, default 4: header errors within one window that force a relock.
REQ-003 The block SHALL have parameter WINDOW, default 64: length of the error-count window, in buffer_dv beats.
REQ-004 The block SHALL have parameter SEEK_TIMEOUT, default 1024: maximum number of buffer_dv beats spent in SEARCH.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port buffer_dv, input, 1 bit: the buffer beat is valid.
REQ-008 The block SHALL have port buffer, input, 67 bits: the current frame buffer.
REQ-009 The block SHALL have port seek_synced_i, input, 1 bit: the is_synced output of the seeker tree.
REQ-010 The block SHALL have port seek_offset_i, input, 7 bits: the offset_pos output of the seeker tree.
REQ-011 The block SHALL have port relock_i, input, 1 bit: a one-cycle request to force a relock.
REQ-012 The block SHALL have port seek_rst_o, output, 1 bit: synchronous reset to the seeker tree.
REQ-013 The block SHALL have port lock_o, output, 1 bit: the header alignment is locked.
REQ-014 The block SHALL have port lock_offset_o, output, 7 bits: the locked header position.
REQ-015 The block SHALL have port hdr_err_cnt_o, output, 16 bits: saturating count of header errors seen while locked.
REQ-016 The block SHALL have port lock_loss_cnt_o, output, 8 bits: saturating count of LOCKED-to-SEEK_RST transitions.

Function
REQ-017 Header check: the header SHALL be hdr = buffer[off+1:off]; it is valid iff hdr is 2'b01 or 2'b10 and off <= 65; off > 65 is always invalid.
REQ-018 The FSM SHALL have four states: SEEK_RST, SEARCH, VERIFY and LOCKED.
REQ-019 SEEK_RST: seek_rst_o=1 for exactly 2 clk_i cycles, regardless of buffer_dv; all counters are cleared; the FSM then goes to SEARCH.
REQ-020 SEARCH: on a beat with buffer_dv=1 and seek_synced_i=1, the FSM SHALL capture seek_offset_i into cand_off and go to VERIFY.
REQ-021 SEARCH: when the beat counter reaches SEEK_TIMEOUT without a sync, the FSM SHALL go to SEEK_RST.
REQ-022 VERIFY: each beat with buffer_dv=1 SHALL check the header at cand_off; a valid header increments good_cnt; an invalid header sends the FSM to SEEK_RST.
REQ-023 VERIFY: on the beat where good_cnt reaches LOCK_CNT, the FSM SHALL go to LOCKED; lock_o=1 and lock_offset_o=cand_off from the next cycle on.
REQ-024 LOCKED: each beat with buffer_dv=1 SHALL increment win_cnt and SHALL increment err_cnt on an invalid header.
REQ-025 LOCKED: when win_cnt reaches WINDOW, both win_cnt and err_cnt SHALL clear.
REQ-026 LOCKED: an error on the closing beat of a window SHALL count toward the closing window before the clear.
REQ-027 LOCKED: when err_cnt reaches UNLOCK_ERR, the FSM SHALL go to SEEK_RST and lock_o SHALL fall in the same cycle that seek_rst_o rises.
REQ-028 seek_offset_i and seek_synced_i SHALL be ignored outside SEARCH; a seeker offset change while LOCKED SHALL NOT alter lock_offset_o.
REQ-029 relock_i=1 SHALL force SEEK_RST on the next edge from any state, with priority over every other transition.
REQ-030 If relock_i is asserted during SEEK_RST, the 2-cycle pulse SHALL restart.
REQ-031 All counters SHALL be sized from their parameters with $clog2, and SHALL NOT wrap.
REQ-032 hdr_err_cnt_o and lock_loss_cnt_o SHALL saturate at all-ones.

Reset
REQ-033 While rst_ni=0, the block SHALL be asynchronously in state SEEK_RST with seek_rst_o=1, lock_o=0, lock_offset_o=0, all counters 0 and cand_off=0.
REQ-034 After rst_ni rises, seek_rst_o SHALL stay high for 2 further cycles, then the FSM goes to SEARCH.

Configuration
REQ-035 The macro HS_LOCK_STATS_EN SHALL control the statistics counters.
REQ-036 With HS_LOCK_STATS_EN defined, hdr_err_cnt_o and lock_loss_cnt_o SHALL be implemented as specified above.
REQ-037 Without HS_LOCK_STATS_EN, both outputs SHALL be tied to 0 and no counter flops SHALL be inferred; the FSM behaviour is identical either way.

Structure
REQ-038 Package hs_lock_pkg SHALL hold the state enum, the constants HDR_DATA=2'b01 and HDR_CTRL=2'b10, and BUF_W=67 and POS_W=7.
REQ-039 Sub-module hs_hdr_check SHALL be combinational: inputs buffer and off, output hdr_ok; the block instantiates it once, muxing off between cand_off and lock_offset_o.

Verification
REQ-040 Scenario: release reset; seek_synced_i=1 with offset 12; 32 valid headers at bit 12. Required: seek_rst_o high for 2 cycles, then lock_o=1 and lock_offset_o=12 one cycle after the 32nd beat.
REQ-041 Scenario: in VERIFY, invalid header 2'b00 on beat 10. Required: SEEK_RST, with seek_rst_o pulsing 2 cycles, and lock_o stays 0.
REQ-042 Scenario: while locked, 3 errors in a 64-beat window, then 3 more in the next window. Required: lock held and hdr_err_cnt_o=6.
REQ-043 Scenario: while locked, 4 errors within one window, the 4th on beat 64. Required: lock_o falls, lock_loss_cnt_o=1, and a seeker reset pulse follows.
REQ-044 Scenario: seek_synced_i=0 for 1024 beats. Required: timeout leads to SEEK_RST, then SEARCH resumes.
REQ-045 Scenario: relock_i while locked, plus rst_ni asserted mid-VERIFY. Required: immediate SEEK_RST; on reset all outputs at their reset values asynchronously; with stats disabled, both counters read 0.
